// File: rtl/i2c_master_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : i2c_master_ctrl_if
// Brief    : Command handshake and SCL/SDA pad bundle for i2c_master_ctrl.
// Revision : 1.0 - initial release
// =============================================================================
interface i2c_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       rx_nack;
    logic [7:0] rx_data;
    logic       done;
    logic       nack;
    logic       cmd_err;
    logic       busy;
    logic       scl_o;
    logic       scl_i;
    logic       sda_oe;
    logic       sda_i;

    // master: the I2C controller itself
    modport master (
        input  cmd_valid, cmd, tx_data, rx_nack, scl_i, sda_i,
        output cmd_ready, rx_data, done, nack, cmd_err, busy, scl_o, sda_oe
    );

    // slave: the host/register-file and pad side
    modport slave (
        output cmd_valid, cmd, tx_data, rx_nack, scl_i, sda_i,
        input  cmd_ready, rx_data, done, nack, cmd_err, busy, scl_o, sda_oe
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : i2c_master_ctrl
// Brief    : Byte-level I2C master sequencer (START/WRITE/READ/STOP) with a
//            quarter-phase SCL timer. Optional slave clock stretching is
//            enabled by defining I2C_CLK_STRETCH_EN.
// Revision : 1.0 - initial release
// =============================================================================
module i2c_master_ctrl #(
    parameter int FCOUNT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_ctrl_if.master  bus
);
    localparam int Q  = FCOUNT / 4;
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [QW-1:0] c_Q_LAST = QW'(Q - 1);
    localparam logic [QW-1:0] c_Q_END  = QW'(Q - 2);

    localparam logic [1:0] c_CMD_START = 2'd0;
    localparam logic [1:0] c_CMD_WRITE = 2'd1;
    localparam logic [1:0] c_CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_phase;
    logic [2:0]      r_bit;
    logic [6:0]      r_tx;
    logic [7:0]      r_rx;
    logic            r_is_read;
    logic            r_rx_nack;
    logic            r_nack_smp;
    logic            r_scl;
    logic            r_sda_oe;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_nack;
    logic            r_cmd_err;
    logic [7:0]      r_rx_data;

    logic w_accept;
    logic w_stall;
    logic w_q_last;
    logic w_sample;
    logic w_finish;

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low while we release it in Q1: freeze the timer.
    assign w_stall = (r_phase == 2'd1) & r_scl & ~bus.scl_i;
`else
    logic w_unused_scl_i;
    assign w_unused_scl_i = bus.scl_i;
    assign w_stall        = 1'b0;
`endif

    assign w_accept = bus.cmd_valid & r_cmd_ready;
    assign w_q_last = (r_qcnt == c_Q_LAST);
    assign w_sample = (r_phase == 2'd1) & w_q_last;
    // Single-bit commands hand over one cycle early so the done cycle is
    // the final cycle of Q3 and a new command can be accepted in it.
    assign w_finish = (r_phase == 2'd3) & (r_qcnt == c_Q_END) &
                      ((r_state == S_START) | (r_state == S_ACK) | (r_state == S_STOP));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 3'd0;
            r_tx        <= 7'd0;
            r_rx        <= 8'd0;
            r_is_read   <= 1'b0;
            r_rx_nack   <= 1'b0;
            r_nack_smp  <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_rx_data   <= 8'd0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        r_qcnt  <= '0;
                        r_phase <= 2'd0;
                        r_bit   <= 3'd0;
                        if (bus.cmd == c_CMD_START) begin
                            r_state     <= S_START;
                            r_scl       <= (r_state == S_IDLE);
                            r_sda_oe    <= 1'b0;
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else if (r_state == S_IDLE) begin
                            r_cmd_err <= 1'b1;
                        end else if ((bus.cmd == c_CMD_WRITE) || (bus.cmd == c_CMD_READ)) begin
                            r_state     <= S_DATA;
                            r_tx        <= bus.tx_data[6:0];
                            r_is_read   <= (bus.cmd == c_CMD_READ);
                            r_rx_nack   <= bus.rx_nack;
                            r_scl       <= 1'b0;
                            r_sda_oe    <= (bus.cmd == c_CMD_WRITE) & ~bus.tx_data[7];
                            r_cmd_ready <= 1'b0;
                        end else begin
                            r_state     <= S_STOP;
                            r_scl       <= 1'b0;
                            r_sda_oe    <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!w_stall) begin
                        if (w_sample && (r_state == S_DATA)) begin
                            r_rx <= {r_rx[6:0], bus.sda_i};
                        end
                        if (w_sample && (r_state == S_ACK)) begin
                            r_nack_smp <= bus.sda_i;
                        end
                        if (w_finish) begin
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            if (r_state == S_STOP) begin
                                r_state  <= S_IDLE;
                                r_scl    <= 1'b1;
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                            end else begin
                                r_state <= S_HOLD;
                                r_scl   <= 1'b0;
                                if (r_state == S_ACK) begin
                                    if (r_is_read) begin
                                        r_rx_data <= r_rx;
                                    end else begin
                                        r_nack <= r_nack_smp;
                                    end
                                end
                            end
                        end else if (w_q_last) begin
                            r_qcnt  <= '0;
                            r_phase <= r_phase + 2'd1;
                            case (r_phase)
                                2'd0: r_scl <= 1'b1;
                                2'd1: begin
                                    r_scl <= 1'b1;
                                    if (r_state == S_START) r_sda_oe <= 1'b1;
                                    if (r_state == S_STOP)  r_sda_oe <= 1'b0;
                                end
                                2'd2: r_scl <= 1'b0;
                                default: begin
                                    // Only DATA reaches the end of Q3 here.
                                    r_scl <= 1'b0;
                                    if (r_bit == 3'd7) begin
                                        r_state  <= S_ACK;
                                        r_bit    <= 3'd0;
                                        r_sda_oe <= r_is_read & ~r_rx_nack;
                                    end else begin
                                        r_bit    <= r_bit + 3'd1;
                                        r_tx     <= {r_tx[5:0], 1'b0};
                                        r_sda_oe <= ~r_is_read & ~r_tx[6];
                                    end
                                end
                            endcase
                        end else begin
                            r_qcnt <= r_qcnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rx_data   = r_rx_data;
    assign bus.done      = r_done;
    assign bus.nack      = r_nack;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.busy      = r_busy;
    assign bus.scl_o     = r_scl;
    assign bus.sda_oe    = r_sda_oe;
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_i2c_master_ctrl
// Brief    : Scoreboard bench for i2c_master_ctrl with a bus-level slave model.
//            Adds a stretch scenario when I2C_CLK_STRETCH_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module tb_i2c_master_ctrl;
    localparam int FCOUNT = 8;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    typedef struct {
        bit         is_err;
        int         acc;
        int         lat;
        bit         exp_nack;
        logic [7:0] exp_rx;
        bit         exp_busy;
        bit         exp_scl;
        bit         exp_sda_oe;
        int         cond;
        bit         is_write;
        bit         is_read;
        logic [7:0] tx;
        bit         rxn;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_master_ctrl_if bus();
    i2c_master_ctrl #(.FCOUNT(FCOUNT)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Reference model state (what the bus should look like after each command)
    exp_t       sb[$];
    bit         m_hold = 1'b0;
    logic [7:0] m_rx = 8'd0;
    bit         m_nack = 1'b0;

    // Slave model: presents byte bits / ACK on SDA, advancing on SCL falls.
    logic [7:0] slv_byte = 8'd0;
    logic       slv_ack = 1'b0;
    logic       slv_read = 1'b0;
    logic       slv_active = 1'b0;
    int         slv_idx = 0;
    logic       prev_scl = 1'b1;
    logic       slave_level;
    logic       sda_line;
    logic       stretch = 1'b0;

    always_comb begin
        slave_level = 1'b1;
        if (slv_active) begin
            if (slv_idx < 8)       slave_level = slv_read ? slv_byte[3'(7 - slv_idx)] : 1'b1;
            else if (slv_idx == 8) slave_level = slv_read ? 1'b1 : slv_ack;
        end
    end
    assign sda_line  = ~bus.sda_oe & slave_level;
    assign bus.sda_i = sda_line;
    assign bus.scl_i = bus.scl_o & ~stretch;

    always @(negedge clk) begin
        prev_scl <= bus.scl_o;
        if (reset) begin
            slv_active <= 1'b0;
            slv_idx    <= 0;
        end else if (bus.cmd_valid && bus.cmd_ready && bus.busy &&
                     (bus.cmd == C_WRITE || bus.cmd == C_READ)) begin
            slv_active <= 1'b1;
            slv_idx    <= 0;
        end else if (bus.done) begin
            slv_active <= 1'b0;
        end else if (slv_active && prev_scl && !bus.scl_o) begin
            slv_idx <= slv_idx + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus-level observations plus scoreboard pop on done/cmd_err.
    initial begin
        logic mscl_prev, msda_prev, saw_start, saw_stop;
        logic [7:0] mon_byte;
        exp_t e;
        mscl_prev = 1'b1; msda_prev = 1'b1; saw_start = 1'b0; saw_stop = 1'b0; mon_byte = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                saw_start = 1'b0;
                saw_stop  = 1'b0;
            end else begin
                if (mscl_prev && bus.scl_o && msda_prev && !sda_line) saw_start = 1'b1;
                if (mscl_prev && bus.scl_o && !msda_prev && sda_line) saw_stop = 1'b1;
                if (!mscl_prev && bus.scl_o && slv_active && sb.size() > 0) begin
                    if (slv_idx < 8) begin
                        mon_byte = {mon_byte[6:0], sda_line};
                    end else if (slv_idx == 8) begin
                        if (sb[0].is_write) check("write_byte_on_bus", int'(mon_byte), int'(sb[0].tx));
                        if (sb[0].is_read)  check("read_ack_bit_on_bus", int'(sda_line), int'(sb[0].rxn));
                    end
                end
                if (bus.done || bus.cmd_err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_pulse", int'(bus.done), int'(!e.is_err));
                        check("cmd_err_pulse", int'(bus.cmd_err), int'(e.is_err));
                        check("latency", cyc - e.acc, e.lat);
                        check("nack", int'(bus.nack), int'(e.exp_nack));
                        check("rx_data", int'(bus.rx_data), int'(e.exp_rx));
                        check("busy", int'(bus.busy), int'(e.exp_busy));
                        check("cmd_ready", int'(bus.cmd_ready), 1);
                        check("scl_at_done", int'(bus.scl_o), int'(e.exp_scl));
                        check("sda_oe_at_done", int'(bus.sda_oe), int'(e.exp_sda_oe));
                        check("start_condition", int'(saw_start), int'(e.cond == 1));
                        check("stop_condition", int'(saw_stop), int'(e.cond == 2));
                    end
                    saw_start = 1'b0;
                    saw_stop  = 1'b0;
                end
            end
            mscl_prev = bus.scl_o;
            msda_prev = sda_line;
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] tx, input logic rxn,
                         input logic [7:0] sbyte, input logic sack, input int extra);
        exp_t e;
        int   w;
        bit   ok;
        @(posedge clk); #1;
        bus.cmd       = c;
        bus.tx_data   = tx;
        bus.rx_nack   = rxn;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 12 * FCOUNT + 50) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1'b1;
            w++;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        slv_byte = sbyte;
        slv_ack  = sack;
        slv_read = (c == C_READ);
        e = '{is_err: 1'b0, acc: cyc, lat: 0, exp_nack: 1'b0, exp_rx: 8'd0, exp_busy: 1'b0,
              exp_scl: 1'b0, exp_sda_oe: 1'b0, cond: 0, is_write: 1'b0, is_read: 1'b0, tx: tx, rxn: rxn};
        if (!m_hold && c != C_START) begin
            e.is_err = 1'b1;
            e.lat    = 1;
        end else begin
            case (c)
                C_START: begin e.lat = FCOUNT; e.cond = 1; e.exp_sda_oe = 1'b1; m_hold = 1'b1; end
                C_WRITE: begin e.lat = 9 * FCOUNT + extra; e.is_write = 1'b1; m_nack = sack; end
                C_READ:  begin e.lat = 9 * FCOUNT + extra; e.is_read = 1'b1; m_rx = sbyte;
                               e.exp_sda_oe = ~rxn; end
                default: begin e.lat = FCOUNT; e.cond = 2; m_hold = 1'b0; end
            endcase
        end
        e.exp_nack = m_nack;
        e.exp_rx   = m_rx;
        e.exp_busy = m_hold;
        e.exp_scl  = !m_hold;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 20 * FCOUNT) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd0;
        bus.tx_data   = 8'd0;
        bus.rx_nack   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_scl", int'(bus.scl_o), 1);
        check("rst_sda_oe", int'(bus.sda_oe), 0);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_nack", int'(bus.nack), 0);
        check("rst_cmd_err", int'(bus.cmd_err), 0);
        check("rst_rx_data", int'(bus.rx_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset asserted in the middle of bit 4 of a WRITE
        issue(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        issue(C_WRITE, 8'h5A, 1'b0, 8'h00, 1'b0, 0);
        repeat (4 * FCOUNT + 3) @(negedge clk);
        check("midwrite_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_scl", int'(bus.scl_o), 1);
        check("midrst_sda_oe", int'(bus.sda_oe), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_cmd_ready", int'(bus.cmd_ready), 1);
        sb.delete();
        m_hold = 1'b0;
        m_rx   = 8'd0;
        m_nack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed scenarios
        issue(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        issue(C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 0);
        issue(C_WRITE, 8'h00, 1'b0, 8'h00, 1'b1, 0);
        issue(C_READ,  8'h00, 1'b1, 8'h3C, 1'b0, 0);
        issue(C_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 0);
        issue(C_WRITE, 8'hFF, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_scl_after_err", int'(bus.scl_o), 1);
        end
        drain();

`ifdef I2C_CLK_STRETCH_EN
        issue(C_START, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        issue(C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, 10);
        begin
            int w;
            w = 0;
            while (!bus.scl_o && w < FCOUNT) begin
                @(negedge clk);
                w++;
            end
            check("stretch_scl_rise_timeout", int'(bus.scl_o), 1);
            stretch = 1'b1;
            repeat (10) @(negedge clk);
            stretch = 1'b0;
        end
        issue(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        drain();
`endif

        // Randomized command stream against the reference model
        for (int i = 0; i < 40; i++) begin
            if (m_hold || ($urandom_range(0, 3) == 0)) c = 2'($urandom_range(0, 3));
            else c = C_START;
            issue(c, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0);
        end
        issue(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
